// File: rtl/nh_window_gen_if.sv
// Pixel-in / window-out stream bundle for nh_window_gen, plus frame control.
// The master side is the pixel source and window consumer; the slave side is the generator.
interface nh_window_gen_if #(
  parameter int DATA_W = 8,
  parameter int NH_DIM = 3
);
  logic                              clear;
  logic                              in_valid;
  logic                              in_ready;
  logic [DATA_W-1:0]                 in_data;
  logic                              out_valid;
  logic                              out_ready;
  logic [NH_DIM*NH_DIM*DATA_W-1:0]   out_nh;
  logic                              frame_done;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_nh, frame_done
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_nh, frame_done
  );
endinterface

// File: rtl/nh_window_gen.sv
// Streaming NH_DIM x NH_DIM neighbourhood generator: raster pixels in, one flat window word
// out for every stride-aligned window position, with output back-pressure and frame counting.
module nh_window_gen #(
  parameter int DATA_W = 8,
  parameter int NH_DIM = 3,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int STRIDE = 1
) (
  input  logic           clock,
  input  logic           reset,
  nh_window_gen_if.slave bus
);

  localparam int CW = (IMG_W  > 1) ? $clog2(IMG_W)  : 1;
  localparam int RW = (IMG_H  > 1) ? $clog2(IMG_H)  : 1;
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int NW = NH_DIM * NH_DIM * DATA_W;

  typedef logic [DATA_W-1:0] pix_t;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [PW-1:0] col_ph_q, col_ph_d;
  logic [PW-1:0] row_ph_q, row_ph_d;
  logic          out_valid_q, out_valid_d;
  logic [NW-1:0] out_nh_q, out_nh_d;
  logic          frame_done_q, frame_done_d;

  pix_t win_q [NH_DIM][NH_DIM];
  pix_t win_d [NH_DIM][NH_DIM];
  pix_t lb_q  [NH_DIM-1][IMG_W];

  logic [NW-1:0] win_flat;
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          col_in_win;
  logic          row_in_win;
  logic          complete;

  assign bus.in_ready   = !out_valid_q || bus.out_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_nh     = out_nh_q;
  assign bus.frame_done = frame_done_q;

  // A pixel presented together with clear is discarded.
  assign accept     = bus.in_valid && bus.in_ready && !bus.clear;
  assign col_last   = (col_q == CW'(IMG_W - 1));
  assign row_last   = (row_q == RW'(IMG_H - 1));
  assign col_in_win = (col_q >= CW'(NH_DIM - 1));
  assign row_in_win = (row_q >= RW'(NH_DIM - 1));
  assign complete   = accept && col_in_win && row_in_win &&
                      (col_ph_q == '0) && (row_ph_q == '0);

  // Shifted window: the new right column is the pre-update line buffer column plus in_data.
  always_comb begin
    // NOTE: always_comb uses blocking '='; every output gets a default first so no latch is inferred.
    win_flat = '0;
    for (int r = 0; r < NH_DIM; r++) begin
      for (int c = 0; c < NH_DIM - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
    end
    for (int r = 0; r < NH_DIM - 1; r++) begin
      win_d[r][NH_DIM-1] = lb_q[NH_DIM-2-r][col_q];
    end
    win_d[NH_DIM-1][NH_DIM-1] = bus.in_data;
    for (int r = 0; r < NH_DIM; r++) begin
      for (int c = 0; c < NH_DIM; c++) begin
        win_flat[(r*NH_DIM+c)*DATA_W +: DATA_W] = win_d[r][c];
      end
    end
  end

  // Phase counters track (pos-(NH_DIM-1)) % STRIDE without a divider; they sit at 0 until the
  // position first reaches NH_DIM-1.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    col_ph_d     = col_ph_q;
    row_ph_d     = row_ph_q;
    out_valid_d  = out_valid_q;
    out_nh_d     = out_nh_q;
    frame_done_d = 1'b0;

    if (accept) begin
      if (col_last) begin
        col_d    = '0;
        col_ph_d = '0;
        if (row_last) begin
          row_d        = '0;
          row_ph_d     = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d    = row_q + RW'(1);
          row_ph_d = (row_in_win && row_ph_q != PW'(STRIDE - 1)) ? row_ph_q + PW'(1) : '0;
        end
      end else begin
        col_d    = col_q + CW'(1);
        col_ph_d = (col_in_win && col_ph_q != PW'(STRIDE - 1)) ? col_ph_q + PW'(1) : '0;
      end
    end

    if (complete) begin
      out_valid_d = 1'b1;
      out_nh_d    = win_flat;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (bus.clear) begin
      col_d        = '0;
      row_d        = '0;
      col_ph_d     = '0;
      row_ph_d     = '0;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      col_ph_q     <= '0;
      row_ph_q     <= '0;
      out_valid_q  <= 1'b0;
      out_nh_q     <= '0;
      frame_done_q <= 1'b0;
      win_q        <= '{default: '0};
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      col_ph_q     <= col_ph_d;
      row_ph_q     <= row_ph_d;
      out_valid_q  <= out_valid_d;
      out_nh_q     <= out_nh_d;
      frame_done_q <= frame_done_d;
      if (accept) begin
        win_q <= win_d;
      end
    end
  end

  // NOTE: line buffers are RAM-like storage with no reset; emission never reads unwritten lines.
  always_ff @(posedge clock) begin
    if (accept) begin
      lb_q[0][col_q] <= bus.in_data;
      for (int k = 1; k < NH_DIM - 1; k++) begin
        lb_q[k][col_q] <= lb_q[k-1][col_q];
      end
    end
  end

endmodule

// File: tb/tb_nh_window_gen.sv
// Directed bench for nh_window_gen: a 4x4 stride-1 instance and a 5x5 stride-2 instance.
// Expected windows are hand-computed from pixel value = row*IMG_W + col + 1 (+ frame offset).
module tb_nh_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n;
  logic rst_b_n;

  nh_window_gen_if #(.DATA_W(8), .NH_DIM(3)) ifa ();
  nh_window_gen_if #(.DATA_W(8), .NH_DIM(3)) ifb ();

  nh_window_gen #(.DATA_W(8), .NH_DIM(3), .IMG_W(4), .IMG_H(4), .STRIDE(1)) dut_a (
    .clock (clk),
    .reset (rst_a_n),
    .bus   (ifa)
  );

  nh_window_gen #(.DATA_W(8), .NH_DIM(3), .IMG_W(5), .IMG_H(5), .STRIDE(2)) dut_b (
    .clock (clk),
    .reset (rst_b_n),
    .bus   (ifb)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [71:0] win_a [$];
  logic [71:0] win_b [$];
  int          fd_a = 0;
  int          fd_b = 0;

  // Record every completed output handshake and frame_done pulse.
  always @(negedge clk) begin
    if (ifa.out_valid && ifa.out_ready) win_a.push_back(ifa.out_nh);
    if (ifb.out_valid && ifb.out_ready) win_b.push_back(ifb.out_nh);
    if (ifa.frame_done) fd_a++;
    if (ifb.frame_done) fd_b++;
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] nh9(input int a, input int b, input int c,
                                      input int d, input int e, input int f,
                                      input int g, input int h, input int i);
    int v [9];
    logic [71:0] res;
    v = '{a, b, c, d, e, f, g, h, i};
    res = '0;
    for (int k = 0; k < 9; k++) res[k*8 +: 8] = 8'(v[k]);
    return res;
  endfunction

  // Drive one pixel and wait (bounded) for it to be accepted; returns 1 ns after the accept edge.
  task automatic push(input bit sel_b, input int d);
    int   t;
    logic rdy;
    t = 0;
    if (sel_b) begin ifb.in_valid = 1'b1; ifb.in_data = 8'(d); end
    else       begin ifa.in_valid = 1'b1; ifa.in_data = 8'(d); end
    @(negedge clk);
    rdy = sel_b ? ifb.in_ready : ifa.in_ready;
    while (!rdy && t < 50) begin
      @(negedge clk);
      rdy = sel_b ? ifb.in_ready : ifa.in_ready;
      t++;
    end
    check($sformatf("push_ready(%0d)", d), 72'(rdy), 72'd1);
    @(posedge clk);
    #1;
    if (sel_b) ifb.in_valid = 1'b0;
    else       ifa.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [71:0] basic_w [4];

  task automatic cmp_basic(input string tag, input int base);
    check($sformatf("%s_count", tag), 72'(win_a.size() - base), 72'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < win_a.size())
        check($sformatf("%s_win%0d", tag, i), win_a[base+i], basic_w[i]);
    end
  endtask

  typedef struct {
    int          data;
    logic        exp_valid;
    logic        exp_done;
    logic [71:0] exp_nh;
  } vec_t;

  vec_t vt [16];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int fdb;
    logic [71:0] exp_b [4];

    basic_w[0] = nh9(1, 2, 3, 5, 6, 7, 9, 10, 11);
    basic_w[1] = nh9(2, 3, 4, 6, 7, 8, 10, 11, 12);
    basic_w[2] = nh9(5, 6, 7, 9, 10, 11, 13, 14, 15);
    basic_w[3] = nh9(6, 7, 8, 10, 11, 12, 14, 15, 16);

    exp_b[0] = nh9(1, 2, 3, 6, 7, 8, 11, 12, 13);
    exp_b[1] = nh9(3, 4, 5, 8, 9, 10, 13, 14, 15);
    exp_b[2] = nh9(11, 12, 13, 16, 17, 18, 21, 22, 23);
    exp_b[3] = nh9(13, 14, 15, 18, 19, 20, 23, 24, 25);

    // Per-pixel expectations for the basic 4x4 frame; out_nh holds its last window between emissions.
    for (int p = 1; p <= 16; p++) begin
      vt[p-1].data      = p;
      vt[p-1].exp_valid = (p == 11 || p == 12 || p == 15 || p == 16);
      vt[p-1].exp_done  = (p == 16);
      vt[p-1].exp_nh    = (p < 11) ? 72'd0 : (p < 12) ? basic_w[0] :
                          (p < 15) ? basic_w[1] : (p < 16) ? basic_w[2] : basic_w[3];
    end

    rst_a_n = 1'b0;  rst_b_n = 1'b0;
    ifa.clear = 1'b0; ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b1;
    ifb.clear = 1'b0; ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b1;
    idle(2);

    check("rst_out_valid",  72'(ifa.out_valid),  72'd0);
    check("rst_out_nh",     ifa.out_nh,          72'd0);
    check("rst_frame_done", 72'(ifa.frame_done), 72'd0);
    check("rst_in_ready",   72'(ifa.in_ready),   72'd1);
    rst_a_n = 1'b1;  rst_b_n = 1'b1;
    idle(1);

    // Basic frame, table-driven.
    for (int i = 0; i < 16; i++) begin
      push(1'b0, vt[i].data);
      check($sformatf("basic_valid(p%0d)", vt[i].data), 72'(ifa.out_valid),  72'(vt[i].exp_valid));
      check($sformatf("basic_done(p%0d)",  vt[i].data), 72'(ifa.frame_done), 72'(vt[i].exp_done));
      check($sformatf("basic_nh(p%0d)",    vt[i].data), ifa.out_nh,          vt[i].exp_nh);
    end
    idle(1);
    check("basic_valid_drop", 72'(ifa.out_valid), 72'd0);

    // Stride 2 on a 5x5 frame.
    for (int p = 1; p <= 25; p++) push(1'b1, p);
    idle(2);
    check("stride_count", 72'(win_b.size()), 72'd4);
    for (int i = 0; i < 4; i++)
      if (i < win_b.size()) check($sformatf("stride_win%0d", i), win_b[i], exp_b[i]);
    check("stride_frame_done", 72'(fd_b), 72'd1);

    // Back-pressure: stall the first window for 5 clock edges with pixel 12 waiting.
    base = win_a.size();
    for (int p = 1; p <= 11; p++) push(1'b0, p);
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_data   = 8'd12;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_in_ready(%0d)", k),  72'(ifa.in_ready),  72'd0);
      check($sformatf("bp_out_valid(%0d)", k), 72'(ifa.out_valid), 72'd1);
      check($sformatf("bp_out_nh(%0d)", k),    ifa.out_nh,         basic_w[0]);
      @(posedge clk);
      #1;
    end
    ifa.out_ready = 1'b1;
    for (int p = 12; p <= 16; p++) push(1'b0, p);
    idle(2);
    cmp_basic("bp", base);

    // Back-to-back frames.
    base = win_a.size();
    fdb  = fd_a;
    for (int p = 1; p <= 16; p++) push(1'b0, p);
    check("b2b_done16", 72'(ifa.frame_done), 72'd1);
    push(1'b0, 101);
    check("b2b_done101", 72'(ifa.frame_done), 72'd0);
    for (int p = 102; p <= 116; p++) push(1'b0, p);
    check("b2b_done116", 72'(ifa.frame_done), 72'd1);
    idle(2);
    check("b2b_count", 72'(win_a.size() - base), 72'd8);
    if (base + 4 < win_a.size())
      check("b2b_first2", win_a[base+4], nh9(101, 102, 103, 105, 106, 107, 109, 110, 111));
    check("b2b_fd_pulses", 72'(fd_a - fdb), 72'd2);

    // Reset mid-frame, then a clean frame.
    for (int p = 1; p <= 9; p++) push(1'b0, p);
    rst_a_n = 1'b0;
    #1;
    check("mid_rst_out_valid",  72'(ifa.out_valid),  72'd0);
    check("mid_rst_out_nh",     ifa.out_nh,          72'd0);
    check("mid_rst_frame_done", 72'(ifa.frame_done), 72'd0);
    idle(2);
    rst_a_n = 1'b1;
    idle(1);
    base = win_a.size();
    fdb  = fd_a;
    for (int p = 1; p <= 16; p++) push(1'b0, p);
    check("mid_rst_done16", 72'(ifa.frame_done), 72'd1);
    idle(2);
    cmp_basic("mid_rst", base);
    check("mid_rst_fd_pulses", 72'(fd_a - fdb), 72'd1);

    // clear after pixel 6; the pixel presented with clear is discarded.
    for (int p = 1; p <= 6; p++) push(1'b0, p);
    ifa.clear    = 1'b1;
    ifa.in_valid = 1'b1;
    ifa.in_data  = 8'hee;
    idle(1);
    ifa.clear    = 1'b0;
    ifa.in_valid = 1'b0;
    base = win_a.size();
    fdb  = fd_a;
    for (int p = 1; p <= 15; p++) push(1'b0, p);
    check("clr_no_early_done", 72'(fd_a - fdb), 72'd0);
    push(1'b0, 16);
    check("clr_done16", 72'(ifa.frame_done), 72'd1);
    idle(2);
    cmp_basic("clr", base);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
